// File: rtl/pim_pkg.sv
// pim_pkg
//   Shared definitions for the PIM crossbar write path and its readers
//   (conv_top consumers): address-width helper, loader state encoding and
//   nibble-split width helpers.
package pim_pkg;

  // Width of the write-pulse down-counter (PULSE_CYC is limited to 1..15).
  localparam int unsigned PULSE_CNT_W = 4;

  // Default weight precision and the matching nibble width.
  localparam int unsigned PIM_W_P_DEFAULT = 8;
  localparam int unsigned PIM_NP_DEFAULT  = PIM_W_P_DEFAULT / 2;

  // Loader state encoding.
  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LOAD   = 3'd1,
    LD_PROG   = 3'd2,
    LD_VERIFY = 3'd3,
    LD_NEXT   = 3'd4,
    LD_DONE   = 3'd5
  } loader_state_e;

  // Number of bits needed to address 'value' entries (minimum 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  // Nibble width for a weight precision (precision must be even).
  function automatic int unsigned nib_width(input int unsigned w_p);
    return w_p / 2;
  endfunction

endpackage

// File: rtl/pim_write_pulse_timer.sv
// pim_write_pulse_timer
//   Load/count-down counter that produces the crossbar write strobe.
//   A load starts a burst of PULSE_CYC consecutive 'we' cycles beginning the
//   cycle after the load; 'expire' marks the final cycle of the burst.
// Ports
//   clk     system clock
//   rst     synchronous active-low reset
//   load    start (or restart) a pulse burst
//   we      write strobe, high for PULSE_CYC cycles after a load
//   expire  high during the last strobe cycle
module pim_write_pulse_timer
  import pim_pkg::*;
#(
  parameter int unsigned PULSE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic we,
  output logic expire
);

  logic [PULSE_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= PULSE_CNT_W'(PULSE_CYC);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - PULSE_CNT_W'(1);
    end
  end

  assign we     = (cnt_q != '0);
  assign expire = (cnt_q == PULSE_CNT_W'(1));

endmodule

// File: rtl/pim_weight_loader.sv
// pim_weight_loader
//   Write side of the PIM crossbar. Takes one column of W_P-bit weights per
//   w_valid/w_ready handshake, holds it, and programs it at the current
//   column address with a PULSE_CYC-cycle write strobe. Upper nibbles drive
//   the HH/LH units, lower nibbles the HL/LL units. DEPTH columns per load,
//   addresses 0..DEPTH-1, then the loader parks in DONE.
//   Optional feature macro: PIM_WRITE_VERIFY_EN (read-back verify with retry).
// Ports
//   clk, rst        clock, synchronous active-low reset
//   start           begin a load (accepted in IDLE or DONE only)
//   w_data/w_valid  column input, row i = w_data[i*W_P +: W_P]
//   w_ready         high only while waiting for a column
//   xbar_addr       column address being programmed
//   xbar_wdata_H/L  upper/lower nibble of each row of the held column
//   xbar_we         write strobe to all four crossbar units
//   xbar_rdata      read-back column (verify build only)
//   busy            load in progress
//   done_flag       load complete
//   err_flag        sticky verify failure (0 without verify)
module pim_weight_loader
  import pim_pkg::*;
#(
  parameter  int unsigned INPUT_SIZE = 32,
  parameter  int unsigned DEPTH      = 32,
  parameter  int unsigned W_P        = PIM_W_P_DEFAULT,
  parameter  int unsigned PULSE_CYC  = 4,
  parameter  int unsigned MAX_RETRY  = 3,
  localparam int unsigned AW         = clogb2(DEPTH),
  localparam int unsigned NP         = nib_width(W_P)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [INPUT_SIZE*W_P-1:0] w_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  output logic [AW-1:0]            xbar_addr,
  output logic [INPUT_SIZE*NP-1:0] xbar_wdata_H,
  output logic [INPUT_SIZE*NP-1:0] xbar_wdata_L,
  output logic                     xbar_we,
  input  logic [INPUT_SIZE*W_P-1:0] xbar_rdata,
  output logic                     busy,
  output logic                     done_flag,
  output logic                     err_flag
);

  localparam int unsigned DW = INPUT_SIZE * W_P;

  loader_state_e state_q, state_d;
  logic [DW-1:0] hold_q;
  logic [AW-1:0] addr_q;
  logic          handshake;
  logic          last_col;
  logic          tmr_load, tmr_expire;
  logic          addr_clr, addr_inc;

  assign handshake = (state_q == LD_LOAD) && w_valid;
  assign last_col  = (addr_q == AW'(DEPTH - 1));

  pim_write_pulse_timer #(
    .PULSE_CYC (PULSE_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .we     (xbar_we),
    .expire (tmr_expire)
  );

`ifdef PIM_WRITE_VERIFY_EN
  localparam int unsigned RW = clogb2(MAX_RETRY + 1);

  logic [RW-1:0] retry_q;
  logic          vwait_q;
  logic          err_q;
  logic          retry_inc, retry_clr, err_set, err_clr;
  logic          rd_match;

  assign rd_match = (xbar_rdata == hold_q);
  assign err_flag = err_q;

  // vwait_q marks the cycle the strobe falls; the compare happens one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retry_q <= '0;
      vwait_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vwait_q <= (state_q == LD_PROG) && tmr_expire;
      if (retry_clr)      retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + RW'(1);
      if (err_clr)        err_q <= 1'b0;
      else if (err_set)   err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{xbar_rdata, MAX_RETRY[0]};
  assign err_flag   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) hold_q <= w_data;
      if (addr_clr)      addr_q <= '0;
      else if (addr_inc) addr_q <= addr_q + AW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    addr_clr = 1'b0;
    addr_inc = 1'b0;
`ifdef PIM_WRITE_VERIFY_EN
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
`endif
    case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d  = LD_LOAD;
          addr_clr = 1'b1;
`ifdef PIM_WRITE_VERIFY_EN
          err_clr  = 1'b1;
`endif
        end
      end
      LD_LOAD: begin
        if (w_valid) begin
          state_d  = LD_PROG;
          tmr_load = 1'b1;
        end
      end
      LD_PROG: begin
        if (tmr_expire) begin
`ifdef PIM_WRITE_VERIFY_EN
          state_d = LD_VERIFY;
`else
          state_d = LD_NEXT;
`endif
        end
      end
`ifdef PIM_WRITE_VERIFY_EN
      LD_VERIFY: begin
        if (!vwait_q) begin
          if (rd_match) begin
            state_d = LD_NEXT;
          end else if (retry_q == RW'(MAX_RETRY)) begin
            state_d = LD_NEXT;
            err_set = 1'b1;
          end else begin
            state_d   = LD_PROG;
            tmr_load  = 1'b1;
            retry_inc = 1'b1;
          end
        end
      end
`endif
      LD_NEXT: begin
`ifdef PIM_WRITE_VERIFY_EN
        retry_clr = 1'b1;
`endif
        if (last_col) begin
          state_d = LD_DONE;
        end else begin
          state_d  = LD_LOAD;
          addr_inc = 1'b1;
        end
      end
      LD_DONE: begin
        if (start) begin
          state_d  = LD_LOAD;
          addr_clr = 1'b1;
`ifdef PIM_WRITE_VERIFY_EN
          err_clr  = 1'b1;
`endif
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    xbar_wdata_H = '0;
    xbar_wdata_L = '0;
    for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
      xbar_wdata_H[i*NP +: NP] = hold_q[i*W_P+NP +: NP];
      xbar_wdata_L[i*NP +: NP] = hold_q[i*W_P +: NP];
    end
  end

  assign xbar_addr = addr_q;
  assign w_ready   = (state_q == LD_LOAD);
  assign done_flag = (state_q == LD_DONE);
  assign busy      = (state_q == LD_LOAD) || (state_q == LD_PROG) ||
                     (state_q == LD_VERIFY) || (state_q == LD_NEXT);

endmodule

// File: tb/tb_pim_weight_loader.sv
// tb_pim_weight_loader
//   Self-checking bench for pim_weight_loader. Each accepted column pushes
//   its expected write (address, H nibbles, L nibbles) into a scoreboard;
//   a negedge monitor pops one entry per write burst and checks address,
//   data stability and burst length. Verify scenario runs only when
//   PIM_WRITE_VERIFY_EN is defined.
module tb_pim_weight_loader;

  localparam int unsigned INPUT_SIZE = 32;
  localparam int unsigned DEPTH      = 32;
  localparam int unsigned W_P        = 8;
  localparam int unsigned NP         = 4;
  localparam int unsigned PULSE_CYC  = 4;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int unsigned AW         = 5;
  localparam int unsigned DW         = INPUT_SIZE * W_P;
  localparam int unsigned HW         = INPUT_SIZE * NP;
`ifdef PIM_WRITE_VERIFY_EN
  localparam int unsigned VEXTRA = 2;
`else
  localparam int unsigned VEXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [AW-1:0] xbar_addr;
  logic [HW-1:0] xbar_wdata_H;
  logic [HW-1:0] xbar_wdata_L;
  logic          xbar_we;
  logic [DW-1:0] xbar_rdata;
  logic          busy;
  logic          done_flag;
  logic          err_flag;

  always #5 clk = ~clk;

  pim_weight_loader #(
    .INPUT_SIZE (INPUT_SIZE),
    .DEPTH      (DEPTH),
    .W_P        (W_P),
    .PULSE_CYC  (PULSE_CYC),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .w_data       (w_data),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .xbar_addr    (xbar_addr),
    .xbar_wdata_H (xbar_wdata_H),
    .xbar_wdata_L (xbar_wdata_L),
    .xbar_we      (xbar_we),
    .xbar_rdata   (xbar_rdata),
    .busy         (busy),
    .done_flag    (done_flag),
    .err_flag     (err_flag)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [HW-1:0] h;
    logic [HW-1:0] l;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   bursts = 0;
  int   we_len = 0;
  bit   we_prev = 1'b0;
  bit   trunc_ok = 1'b0;
  bit   corrupt_en = 1'b0;
  int   col = 0;

  // Crossbar model: reads back what is being written, optionally corrupted at address 5.
  always_comb begin
    xbar_rdata = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      xbar_rdata[i*W_P+NP +: NP] = xbar_wdata_H[i*NP +: NP];
      xbar_rdata[i*W_P +: NP]    = xbar_wdata_L[i*NP +: NP];
    end
    if (corrupt_en && xbar_addr == AW'(5)) xbar_rdata = ~xbar_rdata;
  end

  function automatic exp_t mk_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    logic [W_P-1:0] w;
    e = '0;
    e.addr = a;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      w = d[i*W_P +: W_P];
      e.h[i*NP +: NP] = w[W_P-1:NP];
      e.l[i*NP +: NP] = w[NP-1:0];
    end
    return e;
  endfunction

  // Write monitor: one scoreboard entry per burst, data stable, burst length PULSE_CYC.
  always @(negedge clk) begin
    if (xbar_we === 1'b1) begin
      if (!we_prev) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d, required no write pending", xbar_addr);
          cur = '0;
        end else begin
          cur = sb_q.pop_front();
        end
        bursts++;
        we_len = 0;
      end
      we_len++;
      checks++;
      if (xbar_addr !== cur.addr || xbar_wdata_H !== cur.h || xbar_wdata_L !== cur.l) begin
        errors++;
        $display("FAIL write_data addr=%0d H=%h L=%h, required addr=%0d H=%h L=%h",
                 xbar_addr, xbar_wdata_H, xbar_wdata_L, cur.addr, cur.h, cur.l);
      end
    end else if (we_prev) begin
      if (trunc_ok) begin
        trunc_ok = 1'b0;
      end else begin
        checks++;
        if (we_len != PULSE_CYC) begin
          errors++;
          $display("FAIL pulse_len got %0d cycles, required %0d", we_len, PULSE_CYC);
        end
      end
    end
    we_prev = (xbar_we === 1'b1);
  end

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string what);
    int n;
    n = 0;
    while (w_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (w_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout w_ready=%b, required 1", what, w_ready);
    end
  endtask

  task automatic wait_done(input string what);
    int n;
    n = 0;
    while (done_flag !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_flag !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout done_flag=%b, required 1", what, done_flag);
    end
  endtask

  // Present one column, wait (bounded) for the handshake; lat = negedges waited.
  task automatic send_col(input logic [DW-1:0] d, output int lat);
    int n;
    w_data  = d;
    w_valid = 1'b1;
    n = 0;
    while (w_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (w_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_timeout col=%0d w_ready=%b, required 1", col, w_ready);
    end else begin
      sb_q.push_back(mk_exp(AW'(col), d));
      if (corrupt_en && col == 5) begin
        for (int r = 0; r < int'(MAX_RETRY); r++) sb_q.push_back(mk_exp(AW'(col), d));
      end
      @(negedge clk);
      col++;
    end
    w_valid = 1'b0;
    w_data  = ~d;
    lat = n;
  endtask

  function automatic logic [DW-1:0] rand_col();
    logic [DW-1:0] d;
    for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    start = 1'b1;
    w_valid = 1'b1;
    w_data = '1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    checks++;
    if (w_ready !== 1'b0 || xbar_we !== 1'b0 || xbar_addr !== '0) begin
      errors++;
      $display("FAIL reset_ctrl ready=%b we=%b addr=%0d, required 0 0 0", w_ready, xbar_we, xbar_addr);
    end
    checks++;
    if (xbar_wdata_H !== '0 || xbar_wdata_L !== '0) begin
      errors++;
      $display("FAIL reset_wdata H=%h L=%h, required 0", xbar_wdata_H, xbar_wdata_L);
    end
    checks++;
    if (busy !== 1'b0 || done_flag !== 1'b0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b err=%b, required 0 0 0", busy, done_flag, err_flag);
    end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (w_ready !== 1'b0 || xbar_we !== 1'b0 || xbar_addr !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d ready=%b we=%b addr=%0d busy=%b, required 0 0 0 0",
                 c, w_ready, xbar_we, xbar_addr, busy);
      end
    end
    w_valid = 1'b0;
    checks++;
    if (bursts != 0 || xbar_wdata_H !== '0) begin
      errors++;
      $display("FAIL idle_no_capture bursts=%0d H=%h, required 0 0", bursts, xbar_wdata_H);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int b0;
    logic [DW-1:0] d;
    b0 = bursts;
    col = 0;
    pulse_start;
    checks++;
    if (w_ready !== 1'b1 || busy !== 1'b1 || xbar_addr !== '0 || done_flag !== 1'b0) begin
      errors++;
      $display("FAIL start_accept ready=%b busy=%b addr=%0d done=%b, required 1 1 0 0",
               w_ready, busy, xbar_addr, done_flag);
    end
    d = {INPUT_SIZE{8'hA5}};
    for (int c = 0; c < int'(DEPTH); c++) begin
      send_col(d, lat);
      if (c > 0) begin
        checks++;
        if (lat != int'(PULSE_CYC + 1 + VEXTRA)) begin
          errors++;
          $display("FAIL col_latency col=%0d waited %0d, required %0d", c, lat, PULSE_CYC + 1 + VEXTRA);
        end
      end
      if (c == 0) begin
        checks++;
        if (xbar_wdata_H !== {INPUT_SIZE{4'hA}} || xbar_wdata_L !== {INPUT_SIZE{4'h5}}) begin
          errors++;
          $display("FAIL a5_split H=%h L=%h, required all A / all 5", xbar_wdata_H, xbar_wdata_L);
        end
      end
    end
    wait_done("b2b");
    checks++;
    if (busy !== 1'b0 || w_ready !== 1'b0 || xbar_addr !== AW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL b2b_done_state busy=%b ready=%b addr=%0d, required 0 0 %0d",
               busy, w_ready, xbar_addr, DEPTH - 1);
    end
    checks++;
    if (bursts - b0 != int'(DEPTH) || sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_bursts got %0d pending %0d, required %0d 0", bursts - b0, sb_q.size(), DEPTH);
    end
    w_valid = 1'b1;
    w_data = rand_col();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (w_ready !== 1'b0 || xbar_we !== 1'b0 || done_flag !== 1'b1) begin
        errors++;
        $display("FAIL done_no_accept ready=%b we=%b done=%b, required 0 0 1", w_ready, xbar_we, done_flag);
      end
    end
    w_valid = 1'b0;
  endtask

  task automatic test_gaps_and_start;
    int lat;
    logic [DW-1:0] d;
    pulse_start;
    checks++;
    if (done_flag !== 1'b0 || xbar_addr !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done done=%b addr=%0d busy=%b, required 0 0 1", done_flag, xbar_addr, busy);
    end
    col = 0;
    d = {INPUT_SIZE{8'h3C}};
    for (int c = 0; c < 7; c++) begin
      wait_ready("gap");
      for (int g = 0; g < 5; g++) begin
        w_data = rand_col();
        @(negedge clk);
        checks++;
        if (w_ready !== 1'b1 || xbar_we !== 1'b0 || xbar_addr !== AW'(c)) begin
          errors++;
          $display("FAIL gap_hold col=%0d ready=%b we=%b addr=%0d, required 1 0 %0d",
                   c, w_ready, xbar_we, xbar_addr, c);
        end
      end
      send_col(d, lat);
    end
    wait_ready("addr7");
    pulse_start;
    checks++;
    if (xbar_addr !== AW'(7) || busy !== 1'b1 || w_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_load addr=%0d busy=%b ready=%b, required 7 1 1", xbar_addr, busy, w_ready);
    end
    send_col(rand_col(), lat);
    pulse_start;
    checks++;
    if (xbar_addr !== AW'(7) || xbar_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_prog addr=%0d we=%b busy=%b, required 7 1 1", xbar_addr, xbar_we, busy);
    end
    for (int c = 8; c < int'(DEPTH); c++) send_col(rand_col(), lat);
    wait_done("gaps");
    checks++;
    if (sb_q.size() != 0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL gaps_end pending=%0d err=%b, required 0 0", sb_q.size(), err_flag);
    end
    pulse_start;
    checks++;
    if (xbar_addr !== '0 || done_flag !== 1'b0 || w_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done addr=%0d done=%b ready=%b, required 0 0 1", xbar_addr, done_flag, w_ready);
    end
  endtask

  task automatic test_reset_mid_prog;
    int lat;
    col = 0;
    for (int c = 0; c < 13; c++) send_col(rand_col(), lat);
    @(negedge clk);
    checks++;
    if (xbar_we !== 1'b1 || xbar_addr !== AW'(12)) begin
      errors++;
      $display("FAIL pre_reset_prog we=%b addr=%0d, required 1 12", xbar_we, xbar_addr);
    end
    trunc_ok = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (xbar_we !== 1'b0 || busy !== 1'b0 || xbar_addr !== '0 || w_ready !== 1'b0 || done_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_prog we=%b busy=%b addr=%0d ready=%b done=%b, required 0 0 0 0 0",
               xbar_we, busy, xbar_addr, w_ready, done_flag);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || xbar_we !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b we=%b pending=%0d, required 0 0 0", busy, xbar_we, sb_q.size());
    end
  endtask

`ifdef PIM_WRITE_VERIFY_EN
  task automatic test_verify;
    int lat;
    int b0;
    b0 = bursts;
    corrupt_en = 1'b1;
    col = 0;
    pulse_start;
    for (int c = 0; c < int'(DEPTH); c++) send_col(rand_col(), lat);
    wait_done("verify");
    checks++;
    if (err_flag !== 1'b1 || xbar_addr !== AW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL verify_err err=%b addr=%0d, required 1 %0d", err_flag, xbar_addr, DEPTH - 1);
    end
    checks++;
    if (bursts - b0 != int'(DEPTH + MAX_RETRY) || sb_q.size() != 0) begin
      errors++;
      $display("FAIL verify_bursts got %0d pending %0d, required %0d 0",
               bursts - b0, sb_q.size(), DEPTH + MAX_RETRY);
    end
    corrupt_en = 1'b0;
    pulse_start;
    checks++;
    if (err_flag !== 1'b0 || done_flag !== 1'b0) begin
      errors++;
      $display("FAIL verify_err_clear err=%b done=%b, required 0 0", err_flag, done_flag);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_gaps_and_start;
    test_reset_mid_prog;
`ifdef PIM_WRITE_VERIFY_EN
    test_verify;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
